// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the UART receive path:
//   - rxState_t       : receiver FSM state encoding
//   - DEFAULT_*       : default widths for data and the prescale input
//   - PARITY_EVEN/ODD : encoding of the ParityType input
//   - majority3       : two-out-of-three vote used by the bit sampler
//   - expectedParity  : parity bit a sender would append for a given type
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_PRESCALE_WIDTH = 6;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rxState_t;

    // Two-out-of-three vote, filters a single corrupted sample within a bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity: bit equals XOR of the data. Odd parity: the inverse (XNOR).
    function automatic logic expectedParity(input logic parityType, input logic dataXor);
        return (parityType == PARITY_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// uart_rx_sampler
// ----------------------------------------------------------------------------
// Per-bit edge counter and bit sampler for the UART receiver.
//
// The edge counter runs 0..Prescale-1 across every bit of a frame and wraps
// to 0. o_bitDone flags the last edge of a bit (count == Prescale-1); o_bit
// is the value of that bit, already settled by the time o_bitDone is high.
//
// Configuration macro UART_RX_MAJORITY_EN:
//   defined   -> bit = majority of samples at edges P/2-1, P/2 and P/2+1
//   undefined -> bit = single sample at edge P/2
// Timing is identical in both builds.
//
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_start    : start-bit edge 0 seen in IDLE; counter loads 1
//   i_enable   : a frame is in progress; counter runs and samples are taken
//   i_rx       : serial line, synchronous to i_clk
//   i_prescale : clock cycles per bit (latched by the controller)
//   o_bitDone  : current bit ends on this cycle
//   o_bit      : sampled value of the current bit
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_enable,
    input  logic                      i_rx,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_bitDone,
    output logic                      o_bit
);

    logic [PRESCALE_WIDTH-1:0] r_edgeCnt;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic [PRESCALE_WIDTH-1:0] w_lastEdge;
    logic                      r_sampleMid;

    assign w_half     = i_prescale >> 1;
    assign w_lastEdge = i_prescale - PRESCALE_WIDTH'(1);
    assign o_bitDone  = i_enable && (r_edgeCnt == w_lastEdge);

    // Edge counter. The start edge itself is edge 0 of the start bit, so the
    // counter begins at 1 on the following cycle. Outside a frame it rests at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_edgeCnt <= '0;
        end else if (i_start) begin
            r_edgeCnt <= PRESCALE_WIDTH'(1);
        end else if (i_enable) begin
            if (r_edgeCnt == w_lastEdge) begin
                r_edgeCnt <= '0;
            end else begin
                r_edgeCnt <= r_edgeCnt + PRESCALE_WIDTH'(1);
            end
        end else begin
            r_edgeCnt <= '0;
        end
    end

    // Centre sample, used by both builds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sampleMid <= 1'b1;
        end else if (i_enable && (r_edgeCnt == w_half)) begin
            r_sampleMid <= i_rx;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [PRESCALE_WIDTH-1:0] w_halfEarly;
    logic [PRESCALE_WIDTH-1:0] w_halfLate;
    logic                      r_sampleEarly;
    logic                      r_sampleLate;

    assign w_halfEarly = w_half - PRESCALE_WIDTH'(1);
    assign w_halfLate  = w_half + PRESCALE_WIDTH'(1);

    // Neighbouring samples either side of the centre; all three are captured
    // well before the bit's last edge, so the vote is stable at o_bitDone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sampleEarly <= 1'b1;
            r_sampleLate  <= 1'b1;
        end else if (i_enable) begin
            if (r_edgeCnt == w_halfEarly) begin
                r_sampleEarly <= i_rx;
            end
            if (r_edgeCnt == w_halfLate) begin
                r_sampleLate <= i_rx;
            end
        end
    end

    assign o_bit = majority3(r_sampleEarly, r_sampleMid, r_sampleLate);
`else
    assign o_bit = r_sampleMid;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// uart_rx_ctrl
// ----------------------------------------------------------------------------
// UART receiver: start detection, data shift-in (LSB first), optional parity
// check and stop-bit check. All outputs are registered.
//
// A frame starts on the first IDLE cycle with RX_IN=0 (cycle t). The frame
// result (DataValid, or ParityError/StopError) is a one-cycle pulse exactly
// N*Prescale cycles after t, N = DATA_WIDTH + 2 (+1 with parity). On that
// pulse cycle the receiver is already back in IDLE, so a new start bit can
// begin immediately.
//
// Configuration macro UART_RX_MAJORITY_EN (see uart_rx_sampler): selects
// three-sample majority voting instead of a single centre sample.
//
// Ports:
//   CLK         : clock, rising edge
//   RST         : synchronous active-high reset
//   RX_IN       : serial line, idle high, synchronous to CLK
//   ParityEn    : 1 = a parity bit follows the data bits (latched at t)
//   ParityType  : 0 = even, 1 = odd (latched at t)
//   Prescale    : CLK cycles per bit, 8/16/32 (latched at t)
//   P_DATA      : last good received word; changes only with DataValid
//   DataValid   : one-cycle pulse, frame received without error
//   ParityError : one-cycle pulse at frame end, parity mismatch
//   StopError   : one-cycle pulse at frame end, stop bit sampled 0
//   Busy        : frame in progress
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      ParityEn,
    input  logic                      ParityType,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DataValid,
    output logic                      ParityError,
    output logic                      StopError,
    output logic                      Busy
);

    localparam int                   BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_WIDTH - 1);

    rxState_t r_state;
    rxState_t w_nextState;

    logic                      w_start;
    logic                      w_shiftEn;
    logic                      w_parityCheck;
    logic                      w_frameDone;
    logic                      w_frameGood;
    logic                      w_bitDone;
    logic                      w_bit;
    logic                      w_enable;

    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_parityEn;
    logic                      r_parityType;
    logic [BIT_CNT_W-1:0]      r_bitCnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_parityBad;

    logic [DATA_WIDTH-1:0]     r_pData;
    logic                      r_dataValid;
    logic                      r_parityError;
    logic                      r_stopError;
    logic                      r_busy;

    assign w_enable = (r_state != ST_IDLE);

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_start    (w_start),
        .i_enable   (w_enable),
        .i_rx       (RX_IN),
        .i_prescale (r_prescale),
        .o_bitDone  (w_bitDone),
        .o_bit      (w_bit)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus single-cycle strobes for the datapath. Every
    // transition out of a bit state happens on that bit's last edge.
    always_comb begin
        w_nextState   = r_state;
        w_start       = 1'b0;
        w_shiftEn     = 1'b0;
        w_parityCheck = 1'b0;
        w_frameDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    w_start     = 1'b1;
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                if (w_bitDone) begin
                    // A start bit that samples high was only a glitch.
                    w_nextState = w_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bitDone) begin
                    w_shiftEn = 1'b1;
                    if (r_bitCnt == BIT_LAST) begin
                        w_nextState = r_parityEn ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bitDone) begin
                    w_parityCheck = 1'b1;
                    w_nextState   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bitDone) begin
                    w_frameDone = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Frame context: configuration is frozen at the start edge so that input
    // changes mid-frame cannot disturb timing or the parity decision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale   <= '0;
            r_parityEn   <= 1'b0;
            r_parityType <= 1'b0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_parityBad  <= 1'b0;
        end else begin
            if (w_start) begin
                r_prescale   <= Prescale;
                r_parityEn   <= ParityEn;
                r_parityType <= ParityType;
                r_bitCnt     <= '0;
                r_parityBad  <= 1'b0;
            end
            if (w_shiftEn) begin
                // LSB arrives first, so new bits enter at the top and move down.
                r_shift  <= DATA_WIDTH'({w_bit, r_shift} >> 1);
                r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
            end
            if (w_parityCheck) begin
                r_parityBad <= (w_bit != expectedParity(r_parityType, ^r_shift));
            end
        end
    end

    assign w_frameGood = w_frameDone && !r_parityBad && w_bit;

    // Registered outputs. The pulses land on the cycle after the stop bit's
    // last edge, which is also the first IDLE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pData       <= '0;
            r_dataValid   <= 1'b0;
            r_parityError <= 1'b0;
            r_stopError   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dataValid   <= w_frameGood;
            r_parityError <= w_frameDone && r_parityBad;
            r_stopError   <= w_frameDone && !w_bit;
            r_busy        <= (w_nextState != ST_IDLE);
            if (w_frameGood) begin
                r_pData <= r_shift;
            end
        end
    end

    assign P_DATA      = r_pData;
    assign DataValid   = r_dataValid;
    assign ParityError = r_parityError;
    assign StopError   = r_stopError;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// tb_uart_rx_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for uart_rx_ctrl. Frames are driven on falling edges;
// a negedge monitor accumulates pulse and Busy counts, which each test
// compares against hand-computed expectations.
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b1;
    logic       RX_IN      = 1'b1;
    logic       ParityEn   = 1'b0;
    logic       ParityType = 1'b0;
    logic [5:0] Prescale   = 6'd8;
    logic [7:0] P_DATA;
    logic       DataValid;
    logic       ParityError;
    logic       StopError;
    logic       Busy;

    int checkCnt = 0;
    int errorCnt = 0;
    int cycleCnt = 0;

    int         busyTotal = 0;
    int         dvTotal   = 0;
    int         peTotal   = 0;
    int         seTotal   = 0;
    int         lastDv    = 0;
    int         prevDv    = 0;
    logic [7:0] dvData    = 8'h00;

    int baseBusy, baseDv, basePe, baseSe;

    uart_rx_ctrl #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .ParityEn    (ParityEn),
        .ParityType  (ParityType),
        .Prescale    (Prescale),
        .P_DATA      (P_DATA),
        .DataValid   (DataValid),
        .ParityError (ParityError),
        .StopError   (StopError),
        .Busy        (Busy)
    );

    // Free-running clock and posedge counter used for latency measurement.
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    // Output monitor, sampled mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (Busy) busyTotal++;
        if (DataValid) begin
            prevDv = lastDv;
            lastDv = cycleCnt;
            dvData = P_DATA;
            dvTotal++;
        end
        if (ParityError) peTotal++;
        if (StopError) seTotal++;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            errorCnt++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic clearMonitor();
        baseBusy = busyTotal;
        baseDv   = dvTotal;
        basePe   = peTotal;
        baseSe   = seTotal;
    endtask

    // Drives one frame starting at the current falling edge. After the start
    // bit the configuration inputs are scrambled to confirm they were latched.
    // Returns at the falling edge of the result-pulse cycle with RX_IN idle.
    task automatic applyStimulus(input logic [7:0] data, input int prescale,
                                 input logic parEn, input logic parType,
                                 input logic parBit, input logic stopBit,
                                 output int startCycle);
        Prescale   = 6'(prescale);
        ParityEn   = parEn;
        ParityType = parType;
        startCycle = cycleCnt;
        RX_IN      = 1'b0;
        repeat (prescale) @(negedge CLK);
        Prescale   = (prescale == 8) ? 6'd16 : 6'd8;
        ParityEn   = ~parEn;
        ParityType = ~parType;
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (prescale) @(negedge CLK);
        end
        if (parEn) begin
            RX_IN = parBit;
            repeat (prescale) @(negedge CLK);
        end
        RX_IN = stopBit;
        repeat (prescale) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    initial begin
        int s0;
        int s1;
        int c0;

        // Reset state
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_pdata", P_DATA, 8'h00);
        checkOutput("reset_dv", DataValid, 1'b0);
        checkOutput("reset_pe", ParityError, 1'b0);
        checkOutput("reset_se", StopError, 1'b0);
        checkOutput("reset_busy", Busy, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 0xA5, Prescale 8, no parity: 10 bits * 8 = 80 cycles
        clearMonitor();
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, s0);
        repeat (4) @(negedge CLK);
        checkOutput("a5_dv_count", dvTotal - baseDv, 1);
        checkOutput("a5_data", dvData, 8'hA5);
        checkOutput("a5_latency", lastDv - s0, 80);
        checkOutput("a5_busy_cycles", busyTotal - baseBusy, 79);
        checkOutput("a5_errors", (peTotal - basePe) + (seTotal - baseSe), 0);

        // 0x3C, Prescale 16, even parity, parity bit 0 (four ones): 11*16 = 176
        clearMonitor();
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, s0);
        repeat (4) @(negedge CLK);
        checkOutput("3c_dv_count", dvTotal - baseDv, 1);
        checkOutput("3c_latency", lastDv - s0, 176);
        checkOutput("3c_data", dvData, 8'h3C);
        checkOutput("3c_pe_count", peTotal - basePe, 0);

        // Same frame with a wrong parity bit
        clearMonitor();
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, s0);
        repeat (4) @(negedge CLK);
        checkOutput("badpar_pe_count", peTotal - basePe, 1);
        checkOutput("badpar_dv_count", dvTotal - baseDv, 0);
        checkOutput("badpar_se_count", seTotal - baseSe, 0);
        checkOutput("badpar_pdata_held", P_DATA, 8'h3C);

        // 0xFF with a stop bit of 0
        clearMonitor();
        applyStimulus(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        repeat (4) @(negedge CLK);
        checkOutput("stop_se_count", seTotal - baseSe, 1);
        checkOutput("stop_dv_count", dvTotal - baseDv, 0);
        checkOutput("stop_pdata_held", P_DATA, 8'h3C);

        // 0x07, Prescale 32, odd parity, parity bit 0 (three ones): 11*32 = 352
        clearMonitor();
        applyStimulus(8'h07, 32, 1'b1, 1'b1, 1'b0, 1'b1, s0);
        repeat (4) @(negedge CLK);
        checkOutput("odd_dv_count", dvTotal - baseDv, 1);
        checkOutput("odd_latency", lastDv - s0, 352);
        checkOutput("odd_data", dvData, 8'h07);
        checkOutput("odd_pe_count", peTotal - basePe, 0);

        // Two-cycle low glitch at Prescale 8: Busy for cycles t+1..t+7 only
        Prescale   = 6'd8;
        ParityEn   = 1'b0;
        ParityType = 1'b0;
        clearMonitor();
        c0    = cycleCnt;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        checkOutput("glitch_cycle_offset", cycleCnt - c0, 8);
        checkOutput("glitch_busy_at_t8", Busy, 1'b0);
        checkOutput("glitch_busy_cycles", busyTotal - baseBusy, 7);
        repeat (20) @(negedge CLK);
        checkOutput("glitch_pulses", (dvTotal - baseDv) + (peTotal - basePe) + (seTotal - baseSe), 0);

        // Reset in the middle of the data bits
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (11) @(negedge CLK);
        checkOutput("midreset_busy_before", Busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("midreset_busy_after", Busy, 1'b0);
        checkOutput("midreset_pdata_after", P_DATA, 8'h00);
        checkOutput("midreset_dv_after", DataValid, 1'b0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Two back-to-back 0x12 frames at Prescale 8
        clearMonitor();
        applyStimulus(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, s0);
        applyStimulus(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, s1);
        repeat (4) @(negedge CLK);
        checkOutput("b2b_dv_count", dvTotal - baseDv, 2);
        checkOutput("b2b_data", dvData, 8'h12);
        checkOutput("b2b_first_latency", prevDv - s0, 80);
        checkOutput("b2b_pulse_spacing", lastDv - prevDv, 80);
        checkOutput("b2b_second_latency", lastDv - s1, 80);
        checkOutput("b2b_errors", (peTotal - basePe) + (seTotal - baseSe), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errorCnt);
        $finish;
    end

endmodule
